// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller beside the decode stage: load-use stalls,
// taken-branch flushes and data-memory wait states, plus stall statistics.
//
// state    | meaning
// RUN      | normal issue; hazards resolved combinationally this cycle
// FLUSH    | squashing wrong-path fetches after a taken branch
// MEM_WAIT | data memory busy; front and back of pipe held
// ERROR    | memory never answered; everything held until reset
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_stall,
    output logic                  mem_timeout,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    state_t           ret_state, ret_state_nxt;
    logic [2:0]       flush_cnt, flush_cnt_nxt;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lu, ms;
    logic pc_stall_raw, if_id_stall_raw, if_id_flush_raw;
    logic id_ex_bubble_raw, ex_mem_stall_raw, mem_timeout_raw;

    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign ms = mem_req && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            ret_state   <= RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (pc_stall_raw && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt        = state;
        ret_state_nxt    = ret_state;
        flush_cnt_nxt    = flush_cnt;
        wait_cnt_nxt     = wait_cnt;
        pc_stall_raw     = 1'b0;
        if_id_stall_raw  = 1'b0;
        if_id_flush_raw  = 1'b0;
        id_ex_bubble_raw = 1'b0;
        ex_mem_stall_raw = 1'b0;
        mem_timeout_raw  = 1'b0;

        case (state)
            RUN: begin
                if (ms) begin
                    pc_stall_raw     = 1'b1;
                    if_id_stall_raw  = 1'b1;
                    ex_mem_stall_raw = 1'b1;
                    state_nxt        = MEM_WAIT;
                    ret_state_nxt    = RUN;
                    wait_cnt_nxt     = 8'd1;
                end else if (ex_branch_taken) begin
                    if_id_flush_raw  = 1'b1;
                    id_ex_bubble_raw = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end
                end else if (lu) begin
                    pc_stall_raw     = 1'b1;
                    if_id_stall_raw  = 1'b1;
                    id_ex_bubble_raw = 1'b1;
                end
            end
            FLUSH: begin
                // A memory stall freezes the flush sequence; it resumes on return.
                if (ms) begin
                    pc_stall_raw     = 1'b1;
                    if_id_stall_raw  = 1'b1;
                    ex_mem_stall_raw = 1'b1;
                    state_nxt        = MEM_WAIT;
                    ret_state_nxt    = FLUSH;
                    wait_cnt_nxt     = 8'd1;
                end else begin
                    if_id_flush_raw = 1'b1;
                    flush_cnt_nxt   = flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1)
                        state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                pc_stall_raw     = !mem_ready;
                if_id_stall_raw  = !mem_ready;
                ex_mem_stall_raw = !mem_ready;
                if (mem_ready) begin
                    state_nxt    = ret_state;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt + 8'd1 == WAIT_LIMIT)
                        state_nxt = ERROR;
                end
            end
            default: begin
                pc_stall_raw     = 1'b1;
                if_id_stall_raw  = 1'b1;
                ex_mem_stall_raw = 1'b1;
                mem_timeout_raw  = 1'b1;
            end
        endcase
    end

    assign pc_stall     = pc_stall_raw     && !rst;
    assign if_id_stall  = if_id_stall_raw  && !rst;
    assign if_id_flush  = if_id_flush_raw  && !rst;
    assign id_ex_bubble = id_ex_bubble_raw && !rst;
    assign ex_mem_stall = ex_mem_stall_raw && !rst;
    assign mem_timeout  = mem_timeout_raw  && !rst;
    assign state_o      = rst ? 2'd0 : state;
    assign stall_cnt    = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int BP = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // model: remaining flush cycles, waiting flag, wait length, error flag, stall total
    int m_flush_left, m_wait_len, m_stall;
    bit m_wait, m_err;
    int n_flush_left, n_wait_len, n_stall;
    bit n_wait, n_err;
    bit e_pc, e_ifid, e_flush, e_bub, e_exmem, e_to;
    int e_state, e_cnt;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_PENALTY(BP), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall), .mem_timeout(mem_timeout),
        .state_o(state_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic model_eval();
        bit lu, ms;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        ms = mem_req && !mem_ready;
        {e_pc, e_ifid, e_flush, e_bub, e_exmem, e_to} = '0;
        n_flush_left = m_flush_left; n_wait = m_wait; n_wait_len = m_wait_len; n_err = m_err;
        if (rst) begin
            n_flush_left = 0; n_wait = 0; n_wait_len = 0; n_err = 0;
        end else if (m_err) begin
            e_pc = 1; e_ifid = 1; e_exmem = 1; e_to = 1;
        end else if (m_wait) begin
            e_pc = !mem_ready; e_ifid = !mem_ready; e_exmem = !mem_ready;
            if (mem_ready) begin
                n_wait = 0; n_wait_len = 0;
            end else begin
                n_wait_len = m_wait_len + 1;
                if (n_wait_len == TO) begin n_err = 1; n_wait = 0; end
            end
        end else if (ms) begin
            e_pc = 1; e_ifid = 1; e_exmem = 1;
            n_wait = 1; n_wait_len = 1;
        end else if (m_flush_left > 0) begin
            e_flush = 1; n_flush_left = m_flush_left - 1;
        end else if (ex_branch_taken) begin
            e_flush = 1; e_bub = 1; n_flush_left = BP - 1;
        end else if (lu) begin
            e_pc = 1; e_ifid = 1; e_bub = 1;
        end
        e_state = rst ? 0 : m_err ? 3 : m_wait ? 2 : (m_flush_left > 0) ? 1 : 0;
        e_cnt   = rst ? 0 : m_stall;
        n_stall = rst ? 0 : ((m_stall + int'(e_pc) > 65535) ? 65535 : m_stall + int'(e_pc));
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("pc_stall", pc_stall, e_pc);
        chk("if_id_stall", if_id_stall, e_ifid);
        chk("if_id_flush", if_id_flush, e_flush);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("ex_mem_stall", ex_mem_stall, e_exmem);
        chk("mem_timeout", mem_timeout, e_to);
        chk("state_o", state_o, e_state);
        chk("stall_cnt", stall_cnt, e_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        m_flush_left = n_flush_left; m_wait = n_wait; m_wait_len = n_wait_len;
        m_err = n_err; m_stall = n_stall;
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        tick(); tick();
        idle();
    endtask

    initial begin
        m_flush_left = 0; m_wait = 0; m_wait_len = 0; m_err = 0; m_stall = 0;
        idle();
        @(negedge clk);
        do_reset();
        settle();
        chk("lit_reset_state", state_o, 0);
        chk("lit_reset_cnt", stall_cnt, 0);
        advance();

        // load-use on rs2
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        settle();
        chk("lit_lu_pc_stall", pc_stall, 1);
        chk("lit_lu_bubble", id_ex_bubble, 1);
        advance();
        idle();
        settle();
        chk("lit_lu_once", pc_stall, 0);
        chk("lit_lu_cnt", stall_cnt, 1);
        advance();

        // x0 never hazards
        do_reset();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
        settle();
        chk("lit_x0_stall", pc_stall, 0);
        advance();
        idle();
        settle();
        chk("lit_x0_cnt", stall_cnt, 0);
        advance();

        // taken branch, penalty 2
        ex_branch_taken = 1;
        settle();
        chk("lit_br_flush0", if_id_flush, 1);
        chk("lit_br_bub0", id_ex_bubble, 1);
        chk("lit_br_state0", state_o, 0);
        advance();
        idle();
        settle();
        chk("lit_br_flush1", if_id_flush, 1);
        chk("lit_br_bub1", id_ex_bubble, 0);
        chk("lit_br_state1", state_o, 1);
        advance();
        settle();
        chk("lit_br_flush2", if_id_flush, 0);
        chk("lit_br_state2", state_o, 0);
        advance();

        // memory wait inside a flush
        do_reset();
        ex_branch_taken = 1;
        tick();
        idle();
        mem_req = 1; mem_ready = 0;
        settle();
        chk("lit_fm_noflush", if_id_flush, 0);
        chk("lit_fm_stall", ex_mem_stall, 1);
        advance();
        tick(); tick();
        mem_ready = 1;
        tick();
        idle();
        settle();
        chk("lit_fm_resume_state", state_o, 1);
        chk("lit_fm_resume_flush", if_id_flush, 1);
        chk("lit_fm_cnt", stall_cnt, 3);
        advance();
        settle();
        chk("lit_fm_done", state_o, 0);
        advance();

        // timeout
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TO) tick();
        settle();
        chk("lit_to_state", state_o, 3);
        chk("lit_to_flag", mem_timeout, 1);
        advance();
        idle();
        repeat (3) tick();
        settle();
        chk("lit_to_sticky", mem_timeout, 1);
        advance();
        rst = 1;
        settle();
        chk("lit_to_rst_flag", mem_timeout, 0);
        chk("lit_to_rst_stall", pc_stall, 0);
        chk("lit_to_rst_state", state_o, 0);
        advance();
        idle();
        settle();
        chk("lit_to_after_state", state_o, 0);
        chk("lit_to_after_cnt", stall_cnt, 0);
        advance();

        // load-use and memory stall together
        ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
        mem_req = 1; mem_ready = 0;
        settle();
        chk("lit_lm_exmem", ex_mem_stall, 1);
        chk("lit_lm_bub", id_ex_bubble, 0);
        advance();
        mem_ready = 1;
        settle();
        chk("lit_lm_ready_stall", pc_stall, 0);
        chk("lit_lm_ready_bub", id_ex_bubble, 0);
        advance();
        mem_req = 0;
        settle();
        chk("lit_lm_lu_bub", id_ex_bubble, 1);
        chk("lit_lm_lu_stall", pc_stall, 1);
        advance();
        idle();
        tick();

        // randomized traffic
        begin
            int slow = 0;
            int err_age = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 149) == 0) slow = $urandom_range(10, 40);
                rst             = ($urandom_range(0, 299) == 0) || (err_age > 4);
                id_rs1          = 5'($urandom_range(0, 3));
                id_rs2          = 5'($urandom_range(0, 3));
                ex_rd           = 5'($urandom_range(0, 3));
                id_uses_rs1     = 1'($urandom_range(0, 1));
                id_uses_rs2     = 1'($urandom_range(0, 1));
                ex_mem_read     = ($urandom_range(0, 2) == 0);
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                mem_req         = ($urandom_range(0, 2) == 0) || (slow > 0);
                mem_ready       = (slow > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (slow > 0) slow--;
                tick();
                err_age = m_err ? err_age + 1 : 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
